// File: rtl/vend_pkg.sv
`default_nettype none
// =============================================================================
// Module      : vend_pkg
// Description : Shared types for the multi-item vending controller: FSM state
//               codes, one-hot coin codes and the coin-to-value helper.
// Revision    : 1.0 - initial release
// =============================================================================
package vend_pkg;

    // Codes match the single-item predecessor so existing probes keep working.
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        SELECT        = 3'd1,
        RECEIVE_MONEY = 3'd2,
        COMPARE       = 3'd3,
        PROCESS       = 3'd4,
        RETURN_CHANGE = 3'd5
    } state_t;

    localparam logic [2:0] c_COIN_5    = 3'b001;
    localparam logic [2:0] c_COIN_10   = 3'b010;
    localparam logic [2:0] c_COIN_20   = 3'b100;
    localparam int         c_COIN_VAL_W = 5;

    function automatic logic [c_COIN_VAL_W-1:0] coin_value(input logic [2:0] code);
        logic [c_COIN_VAL_W-1:0] val;
        case (code)
            c_COIN_5:  val = 5'd5;
            c_COIN_10: val = 5'd10;
            c_COIN_20: val = 5'd20;
            default:   val = 5'd0;
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// =============================================================================
// Module      : vend_change_dispenser
// Description : Greedy change coin selection with a valid/ready handshake;
//               requests a credit decrement for every accepted coin.
// Revision    : 1.0 - initial release
// =============================================================================
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int MONEY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_active,
    input  logic [MONEY_W-1:0] i_sum,
    input  logic               i_chg_ready,
    output logic               o_chg_valid,
    output logic [2:0]         o_chg_coin,
    output logic               o_dec_en,
    output logic [MONEY_W-1:0] o_dec_amt
);

    logic       r_valid;
    logic [2:0] r_coin;
    logic [2:0] w_pick;

    always_comb begin
        w_pick = c_COIN_5;
        if (i_sum >= MONEY_W'(20))
            w_pick = c_COIN_20;
        else if (i_sum >= MONEY_W'(10))
            w_pick = c_COIN_10;
    end

    // The offer is only rebuilt after valid has been low for a cycle, so the
    // sum seen here already reflects the previously accepted coin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_coin  <= 3'b000;
        end else if (!i_active) begin
            r_valid <= 1'b0;
            r_coin  <= 3'b000;
        end else if (r_valid) begin
            if (i_chg_ready) begin
                r_valid <= 1'b0;
                r_coin  <= 3'b000;
            end
        end else if (i_sum != '0) begin
            r_valid <= 1'b1;
            r_coin  <= w_pick;
        end
    end

    assign o_chg_valid = r_valid;
    assign o_chg_coin  = r_coin;
    assign o_dec_en    = r_valid & i_chg_ready;
    assign o_dec_amt   = MONEY_W'(coin_value(r_coin));

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// =============================================================================
// Module      : vend_ctrl_multi
// Description : Multi-item vending controller with per-item stock, saturating
//               coin credit, greedy change return and an inactivity refund.
//               Define VEND_MULTI_BUY_EN to keep credit across purchases.
// Revision    : 1.0 - initial release
// =============================================================================
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS   = 4,
    parameter int MONEY_W     = 8,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 3,
    parameter logic [NUM_ITEMS-1:0][MONEY_W-1:0] ITEM_PRICE = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int TIMEOUT_CYC = 255,
    localparam int ITEM_W     = $clog2(NUM_ITEMS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cancel,
    input  logic               continue_buy,
    input  logic [ITEM_W-1:0]  item_in,
    input  logic               coin_valid,
    input  logic [2:0]         coin,
    input  logic               done_money,
    input  logic               restock,
    input  logic [ITEM_W-1:0]  restock_item,
    input  logic               chg_ready,
    output logic [2:0]         state,
    output logic [ITEM_W-1:0]  item_select,
    output logic [MONEY_W-1:0] price,
    output logic [MONEY_W-1:0] sum_money,
    output logic               out_stock,
    output logic               enough_money,
    output logic               vend_valid,
    output logic               chg_valid,
    output logic [2:0]         chg_coin,
    output logic               done,
    output logic               end_trans
);

`ifdef VEND_MULTI_BUY_EN
    localparam bit c_MULTI_EN = 1'b1;
`else
    localparam bit c_MULTI_EN = 1'b0;
`endif
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

    state_t               r_state;
    logic [ITEM_W-1:0]    r_item;
    logic [MONEY_W-1:0]   r_price;
    logic [MONEY_W-1:0]   r_sum;
    logic                 r_vend;
    logic                 r_done;
    logic                 r_end;
    logic                 r_vended;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];

    logic [STOCK_W-1:0]   w_stock_sel;
    logic [MONEY_W-1:0]   w_price_sel;
    logic [c_COIN_VAL_W-1:0] w_coin_val;
    logic                 w_coin_ok;
    logic [MONEY_W:0]     w_sum_wide;
    logic [MONEY_W-1:0]   w_sum_add;
    logic                 w_dec_en;
    logic [MONEY_W-1:0]   w_dec_amt;

    always_comb begin
        w_stock_sel = '0;
        w_price_sel = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_in == ITEM_W'(i)) begin
                w_stock_sel = r_stock[i];
                w_price_sel = ITEM_PRICE[i];
            end
        end
    end

    assign w_coin_val = coin_value(coin);
    assign w_coin_ok  = coin_valid && (w_coin_val != '0);
    assign w_sum_wide = {1'b0, r_sum} + (MONEY_W+1)'(w_coin_val);
    assign w_sum_add  = w_sum_wide[MONEY_W] ? '1 : w_sum_wide[MONEY_W-1:0];

    vend_change_dispenser #(
        .MONEY_W (MONEY_W)
    ) u_dispenser (
        .clk         (clk),
        .rst         (reset),
        .i_active    (r_state == RETURN_CHANGE),
        .i_sum       (r_sum),
        .i_chg_ready (chg_ready),
        .o_chg_valid (chg_valid),
        .o_chg_coin  (chg_coin),
        .o_dec_en    (w_dec_en),
        .o_dec_amt   (w_dec_amt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_item    <= '0;
            r_price   <= '0;
            r_sum     <= '0;
            r_vend    <= 1'b0;
            r_done    <= 1'b0;
            r_end     <= 1'b0;
            r_vended  <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_vend <= 1'b0;
            r_done <= 1'b0;
            r_end  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SELECT;
                        r_vended <= 1'b0;
                    end
                end
                SELECT: begin
                    if (cancel) begin
                        if (c_MULTI_EN && r_sum != '0) begin
                            r_state <= RETURN_CHANGE;
                        end else begin
                            r_state <= IDLE;
                            r_end   <= 1'b1;
                            r_done  <= r_vended;
                        end
                    end else if (!out_stock) begin
                        r_item    <= item_in;
                        r_price   <= w_price_sel;
                        r_tmo_cnt <= '0;
                        r_state   <= RECEIVE_MONEY;
                    end
                end
                RECEIVE_MONEY: begin
                    if (w_coin_ok) begin
                        r_sum     <= w_sum_add;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (cancel)
                        r_state <= RETURN_CHANGE;
                    else if (done_money)
                        r_state <= COMPARE;
                    else if (!w_coin_ok && r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1))
                        r_state <= RETURN_CHANGE;
                end
                COMPARE: begin
                    if (enough_money) begin
                        r_state <= PROCESS;
                        r_vend  <= 1'b1;
                    end else begin
                        r_state   <= RECEIVE_MONEY;
                        r_tmo_cnt <= '0;
                    end
                end
                PROCESS: begin
                    r_sum    <= r_sum - r_price;
                    r_vended <= 1'b1;
                    if (c_MULTI_EN && continue_buy && r_sum != r_price)
                        r_state <= SELECT;
                    else
                        r_state <= RETURN_CHANGE;
                end
                RETURN_CHANGE: begin
                    if (r_sum == '0) begin
                        r_state <= IDLE;
                        r_end   <= 1'b1;
                        r_done  <= r_vended;
                    end else if (w_dec_en) begin
                        r_sum <= r_sum - w_dec_amt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Restock takes priority over a same-cycle vend decrement of that item.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ITEMS; i++)
                r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (restock && restock_item == ITEM_W'(i))
                    r_stock[i] <= '1;
                else if (r_state == PROCESS && r_item == ITEM_W'(i) && r_stock[i] != '0)
                    r_stock[i] <= r_stock[i] - 1'b1;
            end
        end
    end

    assign state        = r_state;
    assign item_select  = r_item;
    assign price        = r_price;
    assign sum_money    = r_sum;
    assign out_stock    = (w_stock_sel == '0);
    assign enough_money = (r_sum >= r_price);
    assign vend_valid   = r_vend;
    assign done         = r_done;
    assign end_trans    = r_end;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_multi.sv
`default_nettype none
// =============================================================================
// Module      : tb_vend_ctrl_multi
// Description : Self-checking bench for vend_ctrl_multi; vends and change coins
//               are scoreboarded, scenario tasks check state and pulses inline.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_vend_ctrl_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, cancel = 1'b0, continue_buy = 1'b0;
    logic       coin_valid = 1'b0, done_money = 1'b0, restock = 1'b0, chg_ready = 1'b1;
    logic [1:0] item_in = 2'd0, restock_item = 2'd0;
    logic [2:0] coin = 3'b000;
    logic [2:0] state;
    logic [1:0] item_select;
    logic [7:0] price, sum_money;
    logic       out_stock, enough_money, vend_valid, chg_valid, done, end_trans;
    logic [2:0] chg_coin;

    int n_cmp = 0;
    int n_err = 0;
    logic [1:0] exp_vend [$];
    logic [2:0] exp_coin [$];
    int m_stock [4];
    int m_price [4] = '{10, 15, 20, 25};
    logic [1:0] mon_item;
    logic [2:0] mon_coin;
    bit ok;

    always #5 clk = ~clk;

    vend_ctrl_multi #(
        .NUM_ITEMS   (4),
        .MONEY_W     (8),
        .STOCK_W     (4),
        .INIT_STOCK  (3),
        .ITEM_PRICE  ({8'd25, 8'd20, 8'd15, 8'd10}),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cancel       (cancel),
        .continue_buy (continue_buy),
        .item_in      (item_in),
        .coin_valid   (coin_valid),
        .coin         (coin),
        .done_money   (done_money),
        .restock      (restock),
        .restock_item (restock_item),
        .chg_ready    (chg_ready),
        .state        (state),
        .item_select  (item_select),
        .price        (price),
        .sum_money    (sum_money),
        .out_stock    (out_stock),
        .enough_money (enough_money),
        .vend_valid   (vend_valid),
        .chg_valid    (chg_valid),
        .chg_coin     (chg_coin),
        .done         (done),
        .end_trans    (end_trans)
    );

    always @(negedge clk) begin
        if (!reset) begin
            if (vend_valid) begin
                n_cmp++;
                if (exp_vend.size() == 0) begin
                    n_err++;
                    $display("FAIL vend_unexpected: item_select=%0d, no vend expected", item_select);
                end else begin
                    mon_item = exp_vend.pop_front();
                    if (item_select !== mon_item) begin
                        n_err++;
                        $display("FAIL vend_item: got %0d, expected %0d", item_select, mon_item);
                    end
                end
            end
            if (chg_valid && chg_ready) begin
                n_cmp++;
                if (exp_coin.size() == 0) begin
                    n_err++;
                    $display("FAIL chg_unexpected: chg_coin=%b, no coin expected", chg_coin);
                end else begin
                    mon_coin = exp_coin.pop_front();
                    if (chg_coin !== mon_coin) begin
                        n_err++;
                        $display("FAIL chg_coin: got %b, expected %b", chg_coin, mon_coin);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] code);
        coin_valid = 1'b1;
        coin       = code;
        tick();
        coin_valid = 1'b0;
        coin       = 3'b000;
    endtask

    task automatic begin_txn(input logic [1:0] item);
        start = 1'b1;
        tick();
        start   = 1'b0;
        item_in = item;
        tick();
    endtask

    task automatic finish_money();
        done_money = 1'b1;
        tick();
        done_money = 1'b0;
    endtask

    task automatic push_change(input int amount);
        int amt;
        amt = amount;
        while (amt > 0) begin
            if (amt >= 20) begin exp_coin.push_back(3'b100); amt -= 20; end
            else if (amt >= 10) begin exp_coin.push_back(3'b010); amt -= 10; end
            else begin exp_coin.push_back(3'b001); amt -= 5; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit reached);
        reached = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (state == 3'd0) begin
                reached = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = 3;
        n_cmp++;
        if (state !== 3'd0 || sum_money !== 8'd0 || price !== 8'd0 || item_select !== 2'd0) begin
            n_err++;
            $display("FAIL reset_regs: state=%0d sum=%0d price=%0d item=%0d, expected all 0",
                     state, sum_money, price, item_select);
        end
        n_cmp++;
        if ({vend_valid, chg_valid, chg_coin, done, end_trans} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_outputs: vend=%b chg_valid=%b coin=%b done=%b end=%b, expected 0",
                     vend_valid, chg_valid, chg_coin, done, end_trans);
        end
    endtask

    task automatic test_buy_change();
        // Item 2 carries the 20 price; 25 paid leaves one 5 coin of change.
        begin_txn(2'd2);
        put_coin(3'b100);
        put_coin(3'b001);
        exp_vend.push_back(2'd2);
        push_change(25 - m_price[2]);
        finish_money();
        n_cmp++;
        if (state !== 3'd3 || price !== 8'd20 || item_select !== 2'd2) begin
            n_err++;
            $display("FAIL t2_compare: state=%0d price=%0d item=%0d, expected 3/20/2", state, price, item_select);
        end
        wait_idle(30, ok);
        m_stock[2]--;
        n_cmp++;
        if (!ok || done !== 1'b1 || end_trans !== 1'b1) begin
            n_err++;
            $display("FAIL t2_end: idle=%b done=%b end_trans=%b, expected 1/1/1", ok, done, end_trans);
        end
        n_cmp++;
        if (dut.r_stock[2] !== 4'(m_stock[2]) || exp_coin.size() != 0 || exp_vend.size() != 0) begin
            n_err++;
            $display("FAIL t2_stock: stock=%0d pending coins=%0d vends=%0d, expected %0d/0/0",
                     dut.r_stock[2], exp_coin.size(), exp_vend.size(), m_stock[2]);
        end
    endtask

    task automatic test_insufficient();
        begin_txn(2'd3);
        put_coin(3'b011);
        n_cmp++;
        if (sum_money !== 8'd0) begin
            n_err++;
            $display("FAIL t3_bad_code: sum=%0d, expected 0", sum_money);
        end
        put_coin(3'b010);
        finish_money();
        n_cmp++;
        if (state !== 3'd3 || enough_money !== 1'b0) begin
            n_err++;
            $display("FAIL t3_short: state=%0d enough=%b, expected 3/0", state, enough_money);
        end
        tick();
        n_cmp++;
        if (state !== 3'd2 || sum_money !== 8'd10) begin
            n_err++;
            $display("FAIL t3_back: state=%0d sum=%0d, expected 2/10", state, sum_money);
        end
        put_coin(3'b100);
        exp_vend.push_back(2'd3);
        push_change(30 - m_price[3]);
        finish_money();
        n_cmp++;
        if (enough_money !== 1'b1) begin
            n_err++;
            $display("FAIL t3_enough: got %b, expected 1", enough_money);
        end
        wait_idle(30, ok);
        m_stock[3]--;
        n_cmp++;
        if (!ok || done !== 1'b1) begin
            n_err++;
            $display("FAIL t3_end: idle=%b done=%b, expected 1/1", ok, done);
        end
    endtask

    task automatic test_out_of_stock();
        for (int k = 0; k < 3; k++) begin
            begin_txn(2'd0);
            put_coin(3'b010);
            exp_vend.push_back(2'd0);
            finish_money();
            wait_idle(20, ok);
            m_stock[0]--;
            n_cmp++;
            if (!ok || done !== 1'b1) begin
                n_err++;
                $display("FAIL t4_buy%0d: idle=%b done=%b, expected 1/1", k, ok, done);
            end
        end
        begin_txn(2'd0);
        n_cmp++;
        if (state !== 3'd1 || out_stock !== 1'b1) begin
            n_err++;
            $display("FAIL t4_empty: state=%0d out_stock=%b, expected 1/1", state, out_stock);
        end
        restock      = 1'b1;
        restock_item = 2'd0;
        tick();
        restock = 1'b0;
        m_stock[0] = 15;
        n_cmp++;
        if (state !== 3'd1 || out_stock !== 1'b0 || dut.r_stock[0] !== 4'd15) begin
            n_err++;
            $display("FAIL t4_restock: state=%0d out_stock=%b stock=%0d, expected 1/0/15",
                     state, out_stock, dut.r_stock[0]);
        end
        tick();
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL t4_resume: state=%0d, expected 2", state);
        end
        // Restock arriving with the vend decrement of the same item must win.
        put_coin(3'b010);
        exp_vend.push_back(2'd0);
        finish_money();
        tick();
        restock = 1'b1;
        tick();
        restock = 1'b0;
        n_cmp++;
        if (dut.r_stock[0] !== 4'd15) begin
            n_err++;
            $display("FAIL t4_restock_prio: stock=%0d, expected 15", dut.r_stock[0]);
        end
        wait_idle(20, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || end_trans !== 1'b1) begin
            n_err++;
            $display("FAIL t4_end: idle=%b done=%b end=%b, expected 1/1/1", ok, done, end_trans);
        end
    endtask

    task automatic test_cancel_stall();
        begin_txn(2'd1);
        put_coin(3'b100);
        put_coin(3'b010);
        chg_ready = 1'b0;
        cancel    = 1'b1;
        done_money = 1'b1;
        tick();
        cancel     = 1'b0;
        done_money = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (state !== 3'd5 || chg_valid !== 1'b1 || chg_coin !== 3'b100 || sum_money !== 8'd30) begin
                n_err++;
                $display("FAIL t5_stall%0d: state=%0d valid=%b coin=%b sum=%0d, expected 5/1/100/30",
                         k, state, chg_valid, chg_coin, sum_money);
            end
            tick();
        end
        push_change(30);
        chg_ready = 1'b1;
        wait_idle(20, ok);
        n_cmp++;
        if (!ok || end_trans !== 1'b1 || done !== 1'b0 || exp_coin.size() != 0) begin
            n_err++;
            $display("FAIL t5_end: idle=%b end=%b done=%b pending=%0d, expected 1/1/0/0",
                     ok, end_trans, done, exp_coin.size());
        end
    endtask

    task automatic test_timeout();
        begin_txn(2'd1);
        put_coin(3'b001);
        for (int k = 0; k < 254; k++) tick();
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++;
            $display("FAIL t6_before: state=%0d after 254 idle cycles, expected 2", state);
        end
        tick();
        n_cmp++;
        if (state !== 3'd5) begin
            n_err++;
            $display("FAIL t6_timeout: state=%0d after 255 idle cycles, expected 5", state);
        end
        push_change(5);
        wait_idle(20, ok);
        n_cmp++;
        if (!ok || end_trans !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL t6_end: idle=%b end=%b done=%b, expected 1/1/0", ok, end_trans, done);
        end
    endtask

    task automatic test_saturate();
        begin_txn(2'd3);
        for (int k = 0; k < 13; k++) put_coin(3'b100);
        n_cmp++;
        if (sum_money !== 8'd255) begin
            n_err++;
            $display("FAIL t7_saturate: sum=%0d, expected 255", sum_money);
        end
        push_change(255);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        wait_idle(60, ok);
        n_cmp++;
        if (!ok || sum_money !== 8'd0 || exp_coin.size() != 0) begin
            n_err++;
            $display("FAIL t7_refund: idle=%b sum=%0d pending=%0d, expected 1/0/0", ok, sum_money, exp_coin.size());
        end
    endtask

    task automatic test_continue_buy();
        begin_txn(2'd0);
        put_coin(3'b100);
        put_coin(3'b001);
        exp_vend.push_back(2'd0);
        continue_buy = 1'b1;
        finish_money();
        tick();
        tick();
        continue_buy = 1'b0;
        m_stock[0]--;
`ifdef VEND_MULTI_BUY_EN
        n_cmp++;
        if (state !== 3'd1 || sum_money !== 8'd15) begin
            n_err++;
            $display("FAIL t8_continue: state=%0d sum=%0d, expected 1/15", state, sum_money);
        end
        push_change(15);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`else
        n_cmp++;
        if (state !== 3'd5 || sum_money !== 8'd15) begin
            n_err++;
            $display("FAIL t8_continue: state=%0d sum=%0d, expected 5/15", state, sum_money);
        end
        push_change(15);
`endif
        wait_idle(30, ok);
        n_cmp++;
        if (!ok || done !== 1'b1 || end_trans !== 1'b1 || dut.r_stock[0] !== 4'(m_stock[0])) begin
            n_err++;
            $display("FAIL t8_end: idle=%b done=%b end=%b stock=%0d, expected 1/1/1/%0d",
                     ok, done, end_trans, dut.r_stock[0], m_stock[0]);
        end
    endtask

    task automatic test_reset_midop();
        begin_txn(2'd1);
        put_coin(3'b010);
        put_coin(3'b001);
        n_cmp++;
        if (state !== 3'd2 || sum_money !== 8'd15) begin
            n_err++;
            $display("FAIL t1_setup: state=%0d sum=%0d, expected 2/15", state, sum_money);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (state !== 3'd0 || sum_money !== 8'd0 || chg_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t1_reset: state=%0d sum=%0d chg_valid=%b, expected 0/0/0", state, sum_money, chg_valid);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut.r_stock[i] !== 4'd3) begin
                n_err++;
                $display("FAIL t1_stock%0d: got %0d, expected 3", i, dut.r_stock[i]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_buy_change();
        test_insufficient();
        test_out_of_stock();
        test_cancel_stall();
        test_timeout();
        test_saturate();
        test_continue_buy();
        test_reset_midop();
        n_cmp++;
        if (exp_vend.size() != 0 || exp_coin.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: vends=%0d coins=%0d left, expected 0/0",
                     exp_vend.size(), exp_coin.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
